// File: rtl/fir_filter.sv
// 64-tap FIR filter using bit-serial distributed arithmetic over an externally loaded 8-bank LUT.
// Optional busy output is enabled by defining FIR_FILTER_BUSY_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a sample strobe (valid_in=1, CLOAD=0)
// S_COMPUTE | one sample bit per cycle, LSB first; bit 15 closes the result
module fir_filter (
   input  logic               clk_fast,
   input  logic               resetn,
   input  logic signed [15:0] din,
   input  logic               valid_in,
   input  logic signed [19:0] CIN,
   input  logic [10:0]        CADDR,
   input  logic               CLOAD,
   output logic signed [38:0] dout,
   output logic               valid_out
`ifdef FIR_FILTER_BUSY_EN
   ,
   output logic               busy
`endif
);

   typedef enum logic {S_IDLE, S_COMPUTE} state_t;

   state_t             state, state_nxt;
   logic [3:0]         bit_cnt;
   logic signed [15:0] taps [64];
   logic signed [19:0] lut [2048];
   logic signed [38:0] acc;
   logic signed [22:0] psum;
   logic signed [38:0] weighted;
   logic signed [38:0] acc_nxt;
   logic               load_sample;
   logic               step;
   logic               finish;

   always_ff @(posedge clk_fast or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (valid_in && !CLOAD) state_nxt = S_COMPUTE;
         S_COMPUTE: if (bit_cnt == 4'd15)   state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      load_sample = 1'b0;
      step        = 1'b0;
      finish      = 1'b0;
      case (state)
         S_IDLE:    load_sample = valid_in && !CLOAD;
         S_COMPUTE: begin
            step   = 1'b1;
            finish = (bit_cnt == 4'd15);
         end
         default: ;
      endcase
   end

`ifdef FIR_FILTER_BUSY_EN
   assign busy = (state == S_COMPUTE);
`endif

   // LUT contents survive reset; they are owned by whoever loads them.
   always_ff @(posedge clk_fast) begin
      if (CLOAD) lut[CADDR] <= CIN;
   end

   always_comb begin
      logic [7:0] idx;
      psum = '0;
      for (int g = 0; g < 8; g++) begin
         idx = '0;
         for (int i = 0; i < 8; i++) idx[i] = taps[g*8+i][bit_cnt];
         psum = psum + {{3{lut[{3'(g), idx}][19]}}, lut[{3'(g), idx}]};
      end
   end

   // Bit 15 is the sample sign bit, so its partial sum carries negative weight.
   always_comb begin
      weighted = {{16{psum[22]}}, psum} <<< bit_cnt;
      acc_nxt  = (bit_cnt == 4'd15) ? acc - weighted : acc + weighted;
   end

   always_ff @(posedge clk_fast or negedge resetn) begin
      if (!resetn) begin
         for (int n = 0; n < 64; n++) taps[n] <= '0;
         acc       <= '0;
         bit_cnt   <= '0;
         dout      <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= finish;
         if (load_sample) begin
            for (int n = 63; n > 0; n--) taps[n] <= taps[n-1];
            taps[0] <= din;
            acc     <= '0;
            bit_cnt <= '0;
         end
         if (step) begin
            acc     <= acc_nxt;
            bit_cnt <= bit_cnt + 4'd1;
         end
         if (finish) dout <= acc_nxt;
      end
   end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: direct-convolution reference model feeding an expected-result queue.
module tb_fir_filter;

   logic               clk_fast = 1'b0;
   logic               resetn;
   logic signed [15:0] din;
   logic               valid_in;
   logic signed [19:0] CIN;
   logic [10:0]        CADDR;
   logic               CLOAD;
   logic signed [38:0] dout;
   logic               valid_out;
`ifdef FIR_FILTER_BUSY_EN
   logic               busy;
`endif

   always #5 clk_fast = ~clk_fast;

   fir_filter dut (
      .clk_fast  (clk_fast),
      .resetn    (resetn),
      .din       (din),
      .valid_in  (valid_in),
      .CIN       (CIN),
      .CADDR     (CADDR),
      .CLOAD     (CLOAD),
      .dout      (dout),
      .valid_out (valid_out)
`ifdef FIR_FILTER_BUSY_EN
      ,
      .busy      (busy)
`endif
   );

   int     n_vec = 0;
   int     n_err = 0;
   longint h    [64];
   longint hist [64];
   longint exp_q[$];

   logic signed [38:0] got;
   int                 lat;
   longint             e;

   function automatic longint conv();
      longint s = 0;
      for (int n = 0; n < 64; n++) s += h[n] * hist[n];
      return s;
   endfunction

   function automatic logic signed [19:0] lut_entry(input int g, input int a);
      longint s = 0;
      for (int i = 0; i < 8; i++) if (a[i]) s += h[g*8+i];
      return 20'(s);
   endfunction

   task automatic load_lut();
      for (int addr = 0; addr < 2048; addr++) begin
         @(negedge clk_fast);
         CLOAD = 1'b1;
         CADDR = 11'(addr);
         CIN   = lut_entry(addr / 256, addr % 256);
      end
      @(negedge clk_fast);
      CLOAD = 1'b0;
   endtask

   task automatic model_accept(input logic signed [15:0] x);
      for (int n = 63; n > 0; n--) hist[n] = hist[n-1];
      hist[0] = longint'(x);
      exp_q.push_back(conv());
   endtask

   task automatic clear_model();
      for (int n = 0; n < 64; n++) hist[n] = 0;
      exp_q.delete();
   endtask

   // Drives one accepted sample and returns dout at the first valid_out plus its latency (-1 on timeout).
   task automatic apply_sample(input logic signed [15:0] x, output logic signed [38:0] obs, output int latency);
      @(negedge clk_fast);
      din      = x;
      valid_in = 1'b1;
      model_accept(x);
      @(posedge clk_fast);
      #1 valid_in = 1'b0;
      latency = -1;
      for (int k = 1; k <= 24; k++) begin
         @(posedge clk_fast);
         #1;
         if (valid_out) begin
            latency = k;
            break;
         end
      end
      obs = dout;
   endtask

   task automatic pop_expected(output longint v);
      if (exp_q.size() == 0) v = 0;
      else v = exp_q.pop_front();
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      din      = '0;
      valid_in = 1'b0;
      CIN      = '0;
      CADDR    = '0;
      CLOAD    = 1'b0;
      clear_model();
      repeat (3) @(posedge clk_fast);
      #1;
      n_vec++;
      if (dout !== 39'sd0 || valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL reset: dout=%0d valid_out=%b, required 0/0", dout, valid_out);
      end
`ifdef FIR_FILTER_BUSY_EN
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy: busy=%b, required 0", busy);
      end
`endif
      @(negedge clk_fast);
      resetn = 1'b1;
   endtask

   task automatic test_impulse();
      for (int n = 0; n < 64; n++) h[n] = n + 1;
      load_lut();
      for (int k = 0; k < 65; k++) begin
         apply_sample((k == 0) ? 16'sd1 : 16'sd0, got, lat);
         pop_expected(e);
         n_vec++;
         if (got !== 39'(e) || lat != 16) begin
            n_err++;
            $display("FAIL impulse[%0d]: dout=%0d latency=%0d, required %0d latency 16", k, got, lat, e);
         end
      end
   endtask

   task automatic test_sign_extreme();
      for (int n = 0; n < 64; n++) h[n] = 0;
      h[0] = -32768;
      load_lut();
      apply_sample(-16'sd32768, got, lat);
      pop_expected(e);
      n_vec++;
      if (got !== 39'(e) || got !== 39'sd1073741824 || lat != 16) begin
         n_err++;
         $display("FAIL sign_neg: dout=%0d latency=%0d, required 1073741824 latency 16", got, lat);
      end
      apply_sample(16'sd32767, got, lat);
      pop_expected(e);
      n_vec++;
      if (got !== 39'(e) || got !== -39'sd1073709056 || lat != 16) begin
         n_err++;
         $display("FAIL sign_pos: dout=%0d latency=%0d, required -1073709056 latency 16", got, lat);
      end
   endtask

   task automatic test_all_max();
      for (int n = 0; n < 64; n++) h[n] = -32768;
      load_lut();
      for (int k = 0; k < 64; k++) begin
         apply_sample(-16'sd32768, got, lat);
         pop_expected(e);
         n_vec++;
         if (got !== 39'(e) || lat != 16) begin
            n_err++;
            $display("FAIL all_max[%0d]: dout=%0d latency=%0d, required %0d latency 16", k, got, lat, e);
         end
      end
      n_vec++;
      if (got !== 39'sd68719476736) begin
         n_err++;
         $display("FAIL all_max_final: dout=%0d, required 68719476736", got);
      end
   endtask

   // valid_in held high: accepts land on edges 0,17,34 and pulses on edges 16,33,50.
   task automatic test_busy_drop();
      logic exp_v;
      for (int k = 0; k < 51; k++) begin
         @(negedge clk_fast);
         din      = 16'(100 + k);
         valid_in = 1'b1;
         if (k % 17 == 0) model_accept(din);
         @(posedge clk_fast);
         #1;
         exp_v = (k % 17 == 16);
         n_vec++;
         if (valid_out !== exp_v) begin
            n_err++;
            $display("FAIL busy_drop_valid[%0d]: valid_out=%b, required %b", k, valid_out, exp_v);
         end
`ifdef FIR_FILTER_BUSY_EN
         n_vec++;
         if (busy !== !exp_v) begin
            n_err++;
            $display("FAIL busy_drop_busy[%0d]: busy=%b, required %b", k, busy, !exp_v);
         end
`endif
         if (valid_out) begin
            pop_expected(e);
            n_vec++;
            if (dout !== 39'(e)) begin
               n_err++;
               $display("FAIL busy_drop_dout[%0d]: dout=%0d, required %0d", k, dout, e);
            end
         end
      end
      @(negedge clk_fast);
      valid_in = 1'b0;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL busy_drop_pending: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      for (int n = 0; n < 64; n++) h[n] = 0;
      h[0] = 2;
      load_lut();
      @(negedge clk_fast);
      din      = 16'sd7;
      valid_in = 1'b1;
      @(posedge clk_fast);
      #1 valid_in = 1'b0;
      repeat (8) @(posedge clk_fast);
      #1 resetn = 1'b0;
      clear_model();
      for (int k = 0; k < 20; k++) begin
         @(posedge clk_fast);
         #1;
         if (valid_out) pulses++;
         if (k == 2) resetn = 1'b1;
      end
      n_vec++;
      if (pulses != 0 || dout !== 39'sd0) begin
         n_err++;
         $display("FAIL reset_mid_abort: pulses=%0d dout=%0d, required 0/0", pulses, dout);
      end
      apply_sample(16'sd5, got, lat);
      pop_expected(e);
      n_vec++;
      if (got !== 39'(e) || got !== 39'sd10 || lat != 16) begin
         n_err++;
         $display("FAIL reset_mid_next: dout=%0d latency=%0d, required 10 latency 16", got, lat);
      end
   endtask

   task automatic test_cload_ignore();
      int pulses = 0;
      @(negedge clk_fast);
      CLOAD    = 1'b1;
      CADDR    = 11'd0;
      CIN      = lut_entry(0, 0);
      din      = 16'sd123;
      valid_in = 1'b1;
      @(negedge clk_fast);
      CLOAD    = 1'b0;
      valid_in = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk_fast);
         #1;
         if (valid_out) pulses++;
      end
      n_vec++;
      if (pulses != 0) begin
         n_err++;
         $display("FAIL cload_ignore: pulses=%0d, required 0", pulses);
      end
      apply_sample(16'sd9, got, lat);
      pop_expected(e);
      n_vec++;
      if (got !== 39'(e) || lat != 16) begin
         n_err++;
         $display("FAIL cload_after: dout=%0d latency=%0d, required %0d latency 16", got, lat, e);
      end
   endtask

   task automatic test_random();
      logic signed [15:0] x;
      for (int n = 0; n < 64; n++) h[n] = longint'($signed(16'($urandom)));
      load_lut();
      for (int k = 0; k < 1000; k++) begin
         x = 16'($urandom);
         apply_sample(x, got, lat);
         pop_expected(e);
         n_vec++;
         if (got !== 39'(e) || lat != 16) begin
            n_err++;
            $display("FAIL random[%0d]: dout=%0d latency=%0d, required %0d latency 16", k, got, lat, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_sign_extreme();
      test_all_max();
      test_busy_drop();
      test_reset_mid();
      test_cload_ignore();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fir_filter.md
FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 The block SHALL have exactly one clock, clk_fast (input, 1 bit), with all state updated on its rising edge; there is no clk_slow port.
REQ-002 The block SHALL have reset resetn (input, 1 bit), asynchronous and active-low.
REQ-003 din: input, 16 bits, signed two's-complement sample.
REQ-004 valid_in: input, 1 bit, sample strobe qualifying din.
REQ-005 CIN: input, 20 bits, signed two's-complement LUT write data.
REQ-006 CADDR: input, 11 bits, LUT write address.
REQ-007 CLOAD: input, 1 bit, LUT write enable.
REQ-008 dout: output, 39 bits, signed filter result.
REQ-009 valid_out: output, 1 bit, one-cycle pulse marking a new dout.

Function
REQ-010 The block SHALL compute the 64-tap FIR result y = sum over n=0..63 of h[n]*x[t-n], using distributed arithmetic with a precomputed LUT rather than multipliers.
REQ-011 LUT: 2048 x 20-bit entries, organised as 8 banks (bank = CADDR[10:8]) of 256 entries (index = CADDR[7:0]).
REQ-012 Entry [g*256+a] SHALL hold the sum of h[g*8+i] over each bit i of a that is set; the LUT is filled externally, not computed by the block.
REQ-013 LUT write: while CLOAD=1, LUT[CADDR] <= CIN on every rising edge; LUT contents are not cleared by reset.
REQ-014 Delay line: 64 x 16-bit taps; tap[0] holds the newest sample and tap[n] holds x[t-n].
REQ-015 FSM states: IDLE and COMPUTE, plus a 4-bit bit counter.
REQ-016 In IDLE, with valid_in=1 and CLOAD=0, at the edge: shift the taps (tap[n] <= tap[n-1], tap[0] <= din), clear the accumulator and counter, and go to COMPUTE.
REQ-017 In COMPUTE, for bit b = counter (0..15, LSB first), each bank g SHALL be read at index {tap[g*8+7][b], ..., tap[g*8+0][b]}, where tap[g*8+i] drives index bit i.
REQ-018 Per-cycle partial sum: the 8 bank outputs added at 23-bit width, sign-extended.
REQ-019 Weighting: partial sum weighted by 2^b for b=0..14 and by -2^15 for b=15 (sign bit); the accumulation SHALL be exact at 39 bits.
REQ-020 After the 16th COMPUTE cycle (bit 15), at that edge: dout <= final sum, valid_out <= 1 for exactly one cycle, and the FSM returns to IDLE.
REQ-021 Latency: valid_out rises 16 rising edges after the acceptance edge.
REQ-022 Throughput: at most one sample per 17 cycles; the earliest next acceptance is the edge after valid_out rises.
REQ-023 dout SHALL hold its value until the next result; a result cannot overflow (|y| <= 2^36).
REQ-024 valid_in SHALL be ignored while in COMPUTE and whenever CLOAD=1; ignored samples are dropped, not queued.
REQ-025 LUT writes during COMPUTE are performed; the result of a computation overlapping a write is not guaranteed.

Reset
REQ-026 While resetn=0: all taps, the accumulator, the counter and dout are cleared to 0, valid_out=0, and the FSM is in IDLE.
REQ-027 Reset asserted mid-COMPUTE SHALL abort the computation with no valid_out pulse.
REQ-028 The first valid_in accepted after reset release is processed normally.

Configuration
REQ-029 Macro FIR_FILTER_BUSY_EN, when defined, SHALL add output busy (1 bit) = 1 exactly while in COMPUTE, reset value 0.
REQ-030 When FIR_FILTER_BUSY_EN is undefined, the port SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-031 Impulse: load LUT for h[n]=n+1, then din=1 followed by 64 zeros -> successive dout values 1, 2, ..., 64, then 0.
REQ-032 Sign extreme: h[0]=-32768, other taps 0, din=-32768 -> dout=1073741824; then din=32767 -> dout=-1073709056.
REQ-033 All-max: all h[n]=-32768 and 64 consecutive samples of -32768 -> final dout=68719476736 (2^36), with no overflow.
REQ-034 Busy drop: valid_in held high continuously -> one accept every 17 cycles; valid_out pulses are 1 cycle wide, 16 edges after each accept; intermediate strobes are dropped.
REQ-035 Reset mid-COMPUTE: resetn pulsed low 8 cycles after an accept -> no valid_out, dout=0; the next accepted din=5 with h[0]=2 -> dout=10.
REQ-036 Random: load 64 random 16-bit coefficients, then 1000 random samples -> each dout equals the reference convolution bit-exactly.
